// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder sequencer.
// The master side is the operand producer and result consumer; the slave side is the controller.
interface serial_add_ctrl_if #(
    parameter int unsigned data_bitsize = 4
);
    localparam int unsigned CNT_W = $clog2(data_bitsize) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [data_bitsize-1:0] a;
    logic [data_bitsize-1:0] b;
    logic                    out_valid;
    logic                    out_ready;
    logic [data_bitsize-1:0] sum;
    logic                    cout;
    logic                    busy;
    logic [CNT_W-1:0]        bit_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy, bit_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy, bit_cnt
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder: loads an operand pair, adds LSB first through a
// single carry flip-flop for data_bitsize cycles, then holds sum/cout until consumed.
module serial_add_ctrl #(
    parameter int unsigned data_bitsize = 4
) (
    input  logic              clk,
    input  logic              reset,
    serial_add_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(data_bitsize) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state;
    logic [data_bitsize-1:0] a_sr;
    logic [data_bitsize-1:0] b_sr;
    logic [data_bitsize-1:0] sum_r;
    logic                    carry;
    logic                    cout_r;
    logic [CNT_W-1:0]        cnt;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;

    logic s_bit;
    logic maj;
    logic last_bit;

    always_comb begin
        s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
        maj      = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_bit = (cnt == CNT_W'(data_bitsize - 1));
    end

    // Status flags are registered next to the state so they always equal its decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_r       <= '0;
            carry       <= 1'b0;
            cout_r      <= 1'b0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr       <= bus.a;
                        b_sr       <= bus.b;
                        carry      <= 1'b0;
                        cnt        <= '0;
                        sum_r      <= '0;
                        state      <= SHIFT;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                SHIFT: begin
                    carry <= maj;
                    sum_r <= {s_bit, sum_r[data_bitsize-1:1]};
                    a_sr  <= {1'b0, a_sr[data_bitsize-1:1]};
                    b_sr  <= {1'b0, b_sr[data_bitsize-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        cout_r      <= maj;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.bit_cnt   = cnt;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: cycle-exact sequences on a 4-bit instance, plus a vector
// table and random sweep on an 8-bit instance, all cross-checked by a scoreboard.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic reset4;
    logic reset8;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.data_bitsize(4)) b4 ();
    serial_add_ctrl_if #(.data_bitsize(8)) b8 ();

    serial_add_ctrl #(.data_bitsize(4)) dut4 (.clk(clk), .reset(reset4), .bus(b4));
    serial_add_ctrl #(.data_bitsize(8)) dut8 (.clk(clk), .reset(reset8), .bus(b8));

    logic [4:0] q4[$];
    logic [8:0] q8[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: reference sums pushed on input handshakes, compared on output handshakes.
    always @(negedge clk) begin
        if (!reset4 && b4.in_valid && b4.in_ready) q4.push_back({1'b0, b4.a} + {1'b0, b4.b});
        if (!reset4 && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) chk("sb4_unexpected_output", 1, 0);
            else chk("sb4_result", {b4.cout, b4.sum}, q4.pop_front());
        end
        if (!reset8 && b8.in_valid && b8.in_ready) q8.push_back({1'b0, b8.a} + {1'b0, b8.b});
        if (!reset8 && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) chk("sb8_unexpected_output", 1, 0);
            else chk("sb8_result", {b8.cout, b8.sum}, q8.pop_front());
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int stall,
                        output logic [7:0] s, output logic c);
        int n;
        b8.a = a; b8.b = b; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        n = 0;
        while (!b8.in_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("run8_accept_timeout", 1, 0);
        step();
        b8.in_valid = 1'b0;
        n = 0;
        while (!b8.out_valid && n < 50) begin step(); n++; end
        if (n >= 50) chk("run8_result_timeout", 1, 0);
        repeat (stall) step();
        s = b8.sum; c = b8.cout;
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;
    endtask

    initial begin
        vec_t       tbl[6];
        logic [7:0] s;
        logic       c;

        tbl[0] = '{a: 8'd200, b: 8'd100, sum: 8'd44,  cout: 1'b1};
        tbl[1] = '{a: 8'd0,   b: 8'd0,   sum: 8'd0,   cout: 1'b0};
        tbl[2] = '{a: 8'd255, b: 8'd1,   sum: 8'd0,   cout: 1'b1};
        tbl[3] = '{a: 8'd255, b: 8'd255, sum: 8'd254, cout: 1'b1};
        tbl[4] = '{a: 8'd128, b: 8'd127, sum: 8'd255, cout: 1'b0};
        tbl[5] = '{a: 8'd1,   b: 8'd1,   sum: 8'd2,   cout: 1'b0};

        reset4 = 1'b1; reset8 = 1'b1;
        b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.out_ready = 1'b0;
        repeat (2) step();
        chk("rst_in_ready",  b4.in_ready,  1);
        chk("rst_out_valid", b4.out_valid, 0);
        chk("rst_busy",      b4.busy,      0);
        chk("rst_sum",       b4.sum,       0);
        chk("rst_cout",      b4.cout,      0);
        chk("rst_bit_cnt",   b4.bit_cnt,   0);
        chk("rst8_in_ready", b8.in_ready,  1);
        @(negedge clk);
        reset4 = 1'b0; reset8 = 1'b0;
        step();

        // 5 + 5: latency and handshake timing
        b4.a = 4'd5; b4.b = 4'd5; b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        chk("s1_in_ready_low", b4.in_ready, 0);
        chk("s1_busy",         b4.busy,     1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("s1_out_valid_timing", b4.out_valid, (k == 4));
        end
        chk("s1_sum",  b4.sum,  10);
        chk("s1_cout", b4.cout, 0);
        step();
        chk("s1_back_idle",  b4.in_ready,  1);
        chk("s1_valid_drop", b4.out_valid, 0);
        chk("s1_sum_kept",   b4.sum,       10);

        // 15 + 1: bit counter progression and carry out
        b4.a = 4'd15; b4.b = 4'd1; b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        chk("s2_bit_cnt_0", b4.bit_cnt, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("s2_bit_cnt", b4.bit_cnt, k);
        end
        chk("s2_sum",  b4.sum,  0);
        chk("s2_cout", b4.cout, 1);
        step();

        // 9 + 7 with consumer back-pressure
        b4.out_ready = 1'b0;
        b4.a = 4'd9; b4.b = 4'd7; b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 3; k++) begin
            chk("s3_hold_valid",   b4.out_valid, 1);
            chk("s3_hold_sum",     b4.sum,       0);
            chk("s3_hold_cout",    b4.cout,      1);
            chk("s3_hold_bit_cnt", b4.bit_cnt,   4);
            step();
        end
        chk("s3_still_valid", b4.out_valid, 1);
        b4.out_ready = 1'b1;
        step();
        chk("s3_handshake_idle", b4.in_ready, 1);
        chk("s3_sb_empty",       q4.size(),   0);

        // in_valid held through SHIFT: next accept exactly 6 edges later
        b4.a = 4'd1; b4.b = 4'd2; b4.in_valid = 1'b1;
        step();
        b4.a = 4'd3; b4.b = 4'd4;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("s4_in_ready_gap", b4.in_ready, (k == 5));
            if (k == 4) chk("s4_first_sum", b4.sum, 3);
        end
        step();
        b4.in_valid = 1'b0;
        chk("s4_second_accept", b4.busy, 1);
        repeat (4) step();
        chk("s4_valid", b4.out_valid, 1);
        chk("s4_sum",   b4.sum,       7);
        chk("s4_cout",  b4.cout,      0);
        step();

        // asynchronous reset mid-SHIFT, then a clean operation
        b4.a = 4'd7; b4.b = 4'd3; b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        repeat (2) step();
        chk("s5_bit_cnt_2", b4.bit_cnt, 2);
        #2 reset4 = 1'b1;
        #1;
        chk("s5_async_in_ready",  b4.in_ready,  1);
        chk("s5_async_out_valid", b4.out_valid, 0);
        chk("s5_async_busy",      b4.busy,      0);
        chk("s5_async_sum",       b4.sum,       0);
        chk("s5_async_cout",      b4.cout,      0);
        chk("s5_async_bit_cnt",   b4.bit_cnt,   0);
        q4.delete();
        @(negedge clk);
        reset4 = 1'b0;
        step();
        b4.a = 4'd6; b4.b = 4'd2; b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        repeat (4) step();
        chk("s5_valid", b4.out_valid, 1);
        chk("s5_sum",   b4.sum,       8);
        chk("s5_cout",  b4.cout,      0);
        step();

        // 8-bit vector table
        for (int i = 0; i < 6; i++) begin
            run8(tbl[i].a, tbl[i].b, i % 3, s, c);
            chk("tbl8_sum",  s, tbl[i].sum);
            chk("tbl8_cout", c, tbl[i].cout);
        end

        // 8-bit random sweep, checked through the scoreboard
        for (int i = 0; i < 220; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 int'($urandom_range(0, 2)), s, c);
        end

        repeat (2) step();
        chk("sb4_drained", q4.size(), 0);
        chk("sb8_drained", q8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
